// File: rtl/prize_pkg.sv
// Encodings shared by the prize spawner and the prize map controller.
package prize_pkg;

   typedef enum logic [2:0] {
      FREE = 3'b000,
      REGU = 3'b001,
      GOLD = 3'b010
   } prize_t;

   localparam int TILE_SHIFT = 6;
   localparam int GRID_ROWS  = 7;
   localparam int GRID_COLS  = 10;

   // Roughly one pick in eight becomes a gold prize.
   function automatic prize_t pick_type(input logic [15:0] rnd);
      return (rnd[10:8] == 3'b111) ? GOLD : REGU;
   endfunction

endpackage

// File: rtl/prize_spawner_if.sv
// Query and write port between the prize spawner (master) and the prize map (slave).
interface prize_spawner_if;
   import prize_pkg::*;

   logic [2:0] qry_row;
   logic [3:0] qry_col;
   prize_t     qry_type;
   logic       wr_valid;
   logic       wr_ready;
   logic [2:0] wr_row;
   logic [3:0] wr_col;
   prize_t     wr_type;

   modport master (
      output qry_row, qry_col, wr_valid, wr_row, wr_col, wr_type,
      input  qry_type, wr_ready
   );

   modport slave (
      input  qry_row, qry_col, wr_valid, wr_row, wr_col, wr_type,
      output qry_type, wr_ready
   );

endinterface

// File: rtl/prize_spawner_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16/14/13/11), reloaded with SEED on reset.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] lfsr
);

   always_ff @(posedge clk) begin
      if (reset)
         lfsr <= SEED;
      else
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

endmodule

// File: rtl/prize_spawner.sv
// Periodically picks a random free grid cell away from Bumpy and writes a prize into the map.
//
// state | meaning
// IDLE  | spawn timer running; waits for period end and room under the cap
// PICK  | take a cell from the LFSR; off-grid picks count as retries
// QUERY | query port driven, map answers next clock
// CHECK | accept a free cell not under Bumpy, else retry
// WRITE | wr_valid held with a stable cell until wr_ready
module prize_spawner
   import prize_pkg::*;
#(
   parameter int          NUM_OF_ROWS  = GRID_ROWS,
   parameter int          NUM_OF_COLS  = GRID_COLS,
   parameter int          SPAWN_PERIOD = 50_000_000,
   parameter int          MAX_PRIZES   = 8,
   parameter int          MAX_RETRIES  = 15,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [10:0]      bumpy_x,
   input  logic [10:0]      bumpy_y,
   input  logic             prize_collected,
   prize_spawner_if.master  map,
   output logic [3:0]       live_count,
   output logic             spawn_done,
   output logic             spawn_fail
);

   localparam int TW = $clog2(SPAWN_PERIOD);
   localparam int RW = $clog2(MAX_RETRIES + 1);

   typedef enum logic [2:0] {IDLE, PICK, QUERY, CHECK, WRITE} spawn_state_t;

   spawn_state_t   state;
   logic [TW-1:0]  timer;
   logic [RW-1:0]  retry;
   prize_t         type_q;
   logic [15:0]    lfsr;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .lfsr  (lfsr)
   );

   logic [2:0]  pick_row;
   logic [3:0]  pick_col;
   logic        pick_ok;
   logic [10:0] bumpy_row;
   logic [10:0] bumpy_col;
   logic        bumpy_hit;
   logic [RW-1:0] retry_next;
   logic        retry_last;
   logic        below_cap;
   logic        handshake;

   assign pick_row   = lfsr[2:0];
   assign pick_col   = lfsr[6:3];
   assign pick_ok    = (32'(pick_row) < NUM_OF_ROWS) && (32'(pick_col) < NUM_OF_COLS);
   assign bumpy_row  = bumpy_y >> TILE_SHIFT;
   assign bumpy_col  = bumpy_x >> TILE_SHIFT;
   assign bumpy_hit  = ({8'd0, map.qry_row} == bumpy_row) && ({7'd0, map.qry_col} == bumpy_col);
   assign retry_next = retry + 1'b1;
   assign retry_last = (retry_next == RW'(MAX_RETRIES));
   assign below_cap  = (32'(live_count) < MAX_PRIZES);
   assign handshake  = (state == WRITE) && map.wr_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         timer       <= '0;
         retry       <= '0;
         type_q      <= FREE;
         live_count  <= '0;
         spawn_done  <= 1'b0;
         spawn_fail  <= 1'b0;
         map.qry_row <= '0;
         map.qry_col <= '0;
         map.wr_valid <= 1'b0;
         map.wr_row  <= '0;
         map.wr_col  <= '0;
         map.wr_type <= FREE;
      end else begin
         spawn_done <= 1'b0;
         spawn_fail <= 1'b0;

         // A collection landing on the write handshake cancels out.
         if (handshake && !prize_collected && below_cap)
            live_count <= live_count + 4'd1;
         else if (!handshake && prize_collected && live_count != 4'd0)
            live_count <= live_count - 4'd1;

         case (state)
            IDLE: begin
               if (enable) begin
                  if (timer == TW'(SPAWN_PERIOD - 1)) begin
                     if (below_cap) begin
                        timer <= '0;
                        retry <= '0;
                        state <= PICK;
                     end
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
            end
            PICK: begin
               type_q <= pick_type(lfsr);
               if (pick_ok) begin
                  map.qry_row <= pick_row;
                  map.qry_col <= pick_col;
                  state       <= QUERY;
               end else if (retry_last) begin
                  spawn_fail <= 1'b1;
                  state      <= IDLE;
               end else begin
                  retry <= retry_next;
               end
            end
            QUERY: state <= CHECK;
            CHECK: begin
               if (map.qry_type == FREE && !bumpy_hit) begin
                  map.wr_valid <= 1'b1;
                  map.wr_row   <= map.qry_row;
                  map.wr_col   <= map.qry_col;
                  map.wr_type  <= type_q;
                  state        <= WRITE;
               end else if (retry_last) begin
                  spawn_fail <= 1'b1;
                  state      <= IDLE;
               end else begin
                  retry <= retry_next;
                  state <= PICK;
               end
            end
            WRITE: begin
               if (map.wr_ready) begin
                  map.wr_valid <= 1'b0;
                  spawn_done   <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prize_spawner.sv
// Directed bench for prize_spawner: a reference LFSR/attempt model predicts each spawn outcome.
module tb_prize_spawner;
   import prize_pkg::*;

   localparam int          PERIOD = 16;
   localparam int          MAXP   = 2;
   localparam int          MAXR   = 4;
   localparam logic [15:0] SEED   = 16'hACE1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [10:0] bumpy_x = '0;
   logic [10:0] bumpy_y = '0;
   logic        prize_collected = 1'b0;
   logic [3:0]  live_count;
   logic        spawn_done;
   logic        spawn_fail;

   prize_spawner_if sif();

   prize_spawner #(
      .SPAWN_PERIOD (PERIOD),
      .MAX_PRIZES   (MAXP),
      .MAX_RETRIES  (MAXR),
      .LFSR_SEED    (SEED)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .bumpy_x         (bumpy_x),
      .bumpy_y         (bumpy_y),
      .prize_collected (prize_collected),
      .map             (sif),
      .live_count      (live_count),
      .spawn_done      (spawn_done),
      .spawn_fail      (spawn_fail)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          next_pick = 0;
   logic [15:0] m_lfsr = SEED;
   bit          map_occ = 1'b0;

   typedef struct {
      bit ok;
      int row;
      int col;
      int typ;
      int cyc;
   } exp_t;
   exp_t sb[$];

   function automatic logic [15:0] step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // Reference timeline: cycle count since reset and the LFSR value in each cycle.
   always @(posedge clk) begin
      if (reset) begin
         cyc    <= 0;
         m_lfsr <= SEED;
      end else begin
         cyc    <= cyc + 1;
         m_lfsr <= step(m_lfsr);
      end
   end

   // Map model: the whole grid is either free or occupied; answer registered one clock after the query.
   always @(posedge clk) sif.qry_type <= map_occ ? REGU : FREE;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Walk one attempt from its PICK cycle; dt is the cycle offset of wr_valid or spawn_fail.
   task automatic predict(input logic [15:0] s0, output exp_t e, input int pick_cyc);
      logic [15:0] s = s0;
      int t = 0, r = 0, brow, bcol;
      brow = int'(bumpy_y >> 6);
      bcol = int'(bumpy_x >> 6);
      e.ok = 1'b0;
      for (int g = 0; g < 64; g++) begin
         e.row = int'(s[2:0]);
         e.col = int'(s[6:3]);
         e.typ = (s[10:8] == 3'b111) ? 2 : 1;
         if (e.row >= 7 || e.col >= 10) begin
            r++;
            if (r == MAXR) begin e.cyc = pick_cyc + t + 1; return; end
            s = step(s);
            t += 1;
         end else if (!map_occ && !(e.row == brow && e.col == bcol)) begin
            e.ok = 1'b1;
            e.cyc = pick_cyc + t + 3;
            return;
         end else begin
            r++;
            if (r == MAXR) begin e.cyc = pick_cyc + t + 3; return; end
            s = step(step(step(s)));
            t += 3;
         end
      end
      e.cyc = -1;
   endtask

   task automatic run_attempt(input int stall, input bit collide, input bit do_reset, output bit ok);
      exp_t e, p;
      int n, live_before;
      n = 0;
      while (cyc < next_pick && n < 200) begin @(negedge clk); n++; end
      check("pick_cycle", cyc, next_pick);
      live_before = int'(live_count);
      predict(m_lfsr, p, cyc);
      sb.push_back(p);
      n = 0;
      while (!sif.wr_valid && !spawn_fail && n < 100) begin @(negedge clk); n++; end
      e = sb.pop_front();
      check("event_seen", int'(sif.wr_valid | spawn_fail), 1);
      check("event_kind_valid", int'(sif.wr_valid), int'(e.ok));
      check("event_cycle", cyc, e.cyc);
      ok = sif.wr_valid;
      if (sif.wr_valid) begin
         check("wr_row", int'(sif.wr_row), e.row);
         check("wr_col", int'(sif.wr_col), e.col);
         check("wr_type", int'(sif.wr_type), e.typ);
         if (do_reset) begin
            sif.wr_ready = 1'b0;
            @(negedge clk);
            check("hold_before_reset", int'(sif.wr_valid), 1);
            reset = 1'b1;
            @(negedge clk);
            check("reset_wr_valid", int'(sif.wr_valid), 0);
            check("reset_live", int'(live_count), 0);
            check("reset_done", int'(spawn_done), 0);
            reset = 1'b0;
            sif.wr_ready = 1'b1;
            next_pick = PERIOD;
         end else begin
            if (stall > 0) begin
               sif.wr_ready = 1'b0;
               for (int i = 0; i < stall; i++) begin
                  @(negedge clk);
                  check("stall_valid", int'(sif.wr_valid), 1);
                  check("stall_row", int'(sif.wr_row), e.row);
                  check("stall_col", int'(sif.wr_col), e.col);
                  check("stall_type", int'(sif.wr_type), e.typ);
                  check("stall_live", int'(live_count), live_before);
               end
               sif.wr_ready = 1'b1;
            end
            if (collide) prize_collected = 1'b1;
            @(negedge clk);
            prize_collected = 1'b0;
            check("done_pulse", int'(spawn_done), 1);
            check("valid_drop", int'(sif.wr_valid), 0);
            check("live_after_write", int'(live_count), collide ? live_before : live_before + 1);
            next_pick = cyc + PERIOD;
            @(negedge clk);
            check("done_single", int'(spawn_done), 0);
         end
      end else begin
         check("fail_live", int'(live_count), live_before);
         next_pick = cyc + PERIOD;
         @(negedge clk);
         check("fail_single", int'(spawn_fail), 0);
      end
   endtask

   task automatic until_ok(input int stall, input bit collide, input bit do_reset);
      bit ok = 1'b0;
      for (int k = 0; k < 12 && !ok; k++) run_attempt(stall, collide, do_reset, ok);
      check("attempt_success", int'(ok), 1);
   endtask

   task automatic collect_once(input int exp_live);
      prize_collected = 1'b1;
      @(negedge clk);
      prize_collected = 1'b0;
      check("collect_live", int'(live_count), exp_live);
   endtask

   initial begin
      bit act;
      logic [2:0] q_row;
      logic [3:0] q_col;
      bit dummy;
      sif.wr_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_wr_valid", int'(sif.wr_valid), 0);
      check("rst_live", int'(live_count), 0);
      check("rst_done", int'(spawn_done), 0);
      check("rst_fail", int'(spawn_fail), 0);
      check("rst_qry", int'({sif.qry_row, sif.qry_col}), 0);
      check("rst_wr_cell", int'({sif.wr_row, sif.wr_col}), 0);
      reset = 1'b0;
      enable = 1'b1;
      next_pick = PERIOD;

      // First spawn into an empty map, Bumpy at cell (0,0).
      until_ok(0, 1'b0, 1'b0);
      check("live_one", int'(live_count), 1);

      // Occupied map: attempts are abandoned and the next starts a full period later.
      map_occ = 1'b1;
      run_attempt(0, 1'b0, 1'b0, dummy);
      run_attempt(0, 1'b0, 1'b0, dummy);
      map_occ = 1'b0;

      // Write held off by wr_ready for five clocks.
      until_ok(5, 1'b0, 1'b0);
      check("live_two", int'(live_count), 2);

      // At the cap nothing is attempted.
      act = 1'b0;
      q_row = sif.qry_row;
      q_col = sif.qry_col;
      repeat (40) begin
         @(negedge clk);
         if (sif.wr_valid || spawn_fail || spawn_done || sif.qry_row != q_row || sif.qry_col != q_col)
            act = 1'b1;
      end
      check("cap_quiet", int'(act), 0);
      collect_once(1);
      next_pick = cyc + 1;

      // Collection coincident with the write handshake.
      until_ok(0, 1'b1, 1'b0);

      // Reset during a stalled write, then the seed replays with Bumpy on cell (3,5).
      bumpy_x = 11'd353;
      bumpy_y = 11'd199;
      until_ok(0, 1'b0, 1'b1);
      until_ok(0, 1'b0, 1'b0);
      collect_once(0);
      collect_once(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
